// File: rtl/mem_stall_ctrl_if.sv
// ============================================================================
// mem_stall_ctrl_if : req/ack bus between the MEM-stage controller and memory
// rev 1.0
// ============================================================================
`default_nettype none

interface mem_stall_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_stall_ctrl.sv
// ============================================================================
// mem_stall_ctrl : multi-cycle data-memory access controller, stalls pipeline
// Optional abort on missing ack when MEM_TIMEOUT_EN is defined.   rev 1.0
// ============================================================================
`default_nettype none

module mem_stall_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  MemReadM,
  input  wire logic                  MemWriteM,
  input  wire logic [ADDR_WIDTH-1:0] addrM,
  input  wire logic [DATA_WIDTH-1:0] wdataM,
  output logic                       stop,
  output logic      [DATA_WIDTH-1:0] rdataM,
  output logic                       err,
  mem_stall_ctrl_if.master           mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_start;
  logic   w_timeout;

  generate
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
      $error("TIMEOUT must be in 1..255");
    end
  endgenerate

  assign w_start     = (r_state == IDLE) && (MemReadM || MemWriteM);
  assign mem.mem_req = (r_state == BUSY);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] C_LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  // The cycle whose no-ack would bring the count to TIMEOUT ends the access.
  assign w_timeout = (r_state == BUSY) && !mem.mem_ack && (r_cnt == C_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 8'd0;
      err   <= 1'b0;
    end else begin
      err <= w_timeout;
      if (w_start) begin
        r_cnt <= 8'd0;
      end else if ((r_state == BUSY) && !mem.mem_ack) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    stop   = 1'b0;
    case (r_state)
      IDLE: begin
        if (MemReadM || MemWriteM) begin
          stop   = 1'b1;
          w_next = BUSY;
        end
      end
      BUSY: begin
        stop = 1'b1;
        if (mem.mem_ack || w_timeout) begin
          w_next = DONE;
        end
      end
      // Stall released for one cycle; requests seen here wait for IDLE.
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_we    <= 1'b0;
      rdataM        <= '0;
    end else begin
      if (w_start) begin
        mem.mem_addr  <= addrM;
        mem.mem_wdata <= wdataM;
        mem.mem_we    <= MemWriteM;
      end
      if ((r_state == BUSY) && !mem.mem_we) begin
        if (mem.mem_ack) begin
          rdataM <= mem.mem_rdata;
        end else if (w_timeout) begin
          rdataM <= '1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Multi-cycle data-memory access controller for the MEM stage of the 16-bit pipelined processor. It converts single-cycle MEM-stage load/store requests into a req/ack handshake with a slow data memory, and drives the `stop` stall request into the hazard unit until the access completes. This block is the stall requester on the hazard unit's `stop` input.

## Interface
- `ADDR_WIDTH`, 16, memory address width
- `DATA_WIDTH`, 16, data word width
- `TIMEOUT`, 15, max BUSY cycles without ack before abort (1..255)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `MemReadM`  in  1  MEM-stage load
- `MemWriteM`  in  1  MEM-stage store
- `addrM`  in  ADDR_WIDTH  MEM-stage address
- `wdataM`  in  DATA_WIDTH  MEM-stage store data
- `stop`  out  1  stall request to hazard unit
- `rdataM`  out  DATA_WIDTH  load result to MEM/WB register
- `err`  out  1  one-cycle pulse on timeout abort
- `mem_req`  out  1  request to memory
- `mem_we`  out  1  1 = write, 0 = read
- `mem_addr`  out  ADDR_WIDTH  latched address
- `mem_wdata`  out  DATA_WIDTH  latched write data
- `mem_ack`  in  1  memory completion
- `mem_rdata`  in  DATA_WIDTH  read data, valid with `mem_ack`

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if `MemReadM | MemWriteM`, then `stop` = 1 combinationally, latch `addrM`/`wdataM`/`mem_we`, clear counter, go BUSY. Otherwise `stop` = 0.
- Both read and write asserted: treated as write.
- BUSY: `mem_req` = 1, `stop` = 1. On `mem_ack`: if read, capture `mem_rdata` into `rdataM`; go DONE.
- DONE: `stop` = 0 for exactly one cycle so the pipeline advances past the access. No new access is started in DONE, even if `MemReadM`/`MemWriteM` are asserted. Go IDLE.
- `rdataM` holds its value until the next completed read. Writes do not modify it.
- `mem_ack` outside BUSY is ignored.
- `mem_addr`, `mem_wdata` and `mem_we` hold their values from the IDLE→BUSY edge until the next access is latched.
- Reset (any time, including mid-BUSY): state IDLE, `mem_req` 0, `stop` 0, `err` 0, `rdataM`/`mem_addr`/`mem_wdata` 0, `mem_we` 0, counter 0. An in-flight access is abandoned.

## Timing
- `mem_req` is registered (decoded from state). It rises the cycle after the access is seen in IDLE.
- Earliest `mem_ack` is the first BUSY cycle.
- Minimum access: stop high for 2 cycles (IDLE cycle and one BUSY cycle with ack), then low in DONE.
- General case: `stop` high for 1 + N cycles, where N is the number of BUSY cycles up to and including the ack cycle.
- `rdataM` is valid from the DONE cycle onward.
- `mem_req` falls on the edge after ack.
- Back-to-back accesses: minimum 3 cycles per access (IDLE, BUSY, DONE).

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter increments each BUSY cycle without ack.
  - When the counter reaches `TIMEOUT` without ack, go DONE, pulse `err` for 1 cycle (aligned to DONE), and for a read set `rdataM` to all-ones.
  - Ack in the same cycle the limit is reached takes priority: normal completion, no `err`.
- Not defined: no counter; BUSY waits indefinitely and `err` is tied to 0.

## Test plan
- Load, ack in first BUSY cycle, `mem_rdata`=16'hA5A5:
  - `stop` high 2 cycles, then low 1 cycle.
  - `rdataM`=16'hA5A5 in DONE.
  - `mem_req` high 1 cycle.
- Store `addrM`=16'h0040, `wdataM`=16'h1234, ack after 4 BUSY cycles:
  - `mem_we`=1, `mem_addr`=16'h0040, `mem_wdata`=16'h1234 throughout BUSY.
  - `stop` high 5 cycles.
  - `rdataM` unchanged.
- Two consecutive loads with `MemReadM` held high, each acked on its first BUSY cycle: two distinct `mem_req` pulses 3 cycles apart; `stop` pattern 1,1,0,1,1,0.
- Reset: `rst` low during BUSY of a load, then ack arrives after release → `mem_req` and `stop` drop asynchronously; the late ack is ignored; `rdataM`=0.
- `MEM_TIMEOUT_EN`, `TIMEOUT`=15, no ack on a load → `stop` high 16 cycles; `err` pulses in DONE; `rdataM`=16'hFFFF.
- Stray `mem_ack` while IDLE with no access → no state change; `stop` stays 0.
